// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB TX CRC16 sequencing logic.
package usb_tx_pkg;

  localparam int CRC_W = 16;
  localparam logic [CRC_W-1:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    DATA,
    INVERT,
    LATCH,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/usb_tx_crc_serializer.sv
// Holds the captured CRC and walks it out one bit per shift, counting bits
// so the sequencer knows when the sixteenth has gone.
module usb_tx_crc_serializer
  import usb_tx_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             i_load,
  input  logic [CRC_W-1:0] i_data,
  input  logic             i_shift,
  output logic             o_head,
  output logic             o_last
);

  logic [CRC_W-1:0] r_shreg;
  logic [3:0]       r_cnt;

  // Load has priority so a stray strobe during capture cannot skew the count
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_shreg <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_shreg <= i_data;
      r_cnt   <= '0;
    end else if (i_shift) begin
      if (MSB_FIRST)
        r_shreg <= {r_shreg[CRC_W-2:0], 1'b0};
      else
        r_shreg <= {1'b0, r_shreg[CRC_W-1:1]};
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign o_head = MSB_FIRST ? r_shreg[CRC_W-1] : r_shreg[0];
  assign o_last = (r_cnt == 4'd15);

endmodule

// File: rtl/usb_tx_crc_sequencer.sv
// Sequences the bit-serial CRC16 generator: clear, gated update, complement,
// capture, then serialization of the 16 CRC bits onto the TX stream.
module usb_tx_crc_sequencer
  import usb_tx_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             i_tx_start,
  input  logic             i_zero_len,
  input  logic             i_bit_strobe,
  input  logic             i_payload_last,
  input  logic             i_tx_abort,
  input  logic [CRC_W-1:0] i_crc_in,
  output logic             o_clear_crc,
  output logic             o_crc_enable,
  output logic             o_crc_flag,
  output logic             o_crc_bit_out,
  output logic             o_crc_bit_valid,
  output logic             o_crc_busy,
  output logic             o_crc_done
);

  state_t r_state;
  state_t w_next;
  logic   r_zero_len;
  logic   w_abort;
  logic   w_load;
  logic   w_shift;
  logic   w_head;
  logic   w_last;

  assign w_abort = i_tx_abort && (r_state != IDLE);
  assign w_load  = (r_state == LATCH) && !w_abort;
  assign w_shift = (r_state == SHIFT) && i_bit_strobe && !w_abort;

  usb_tx_crc_serializer #(
    .MSB_FIRST (MSB_FIRST)
  ) u_serializer (
    .clk     (clk),
    .n_rst   (n_rst),
    .i_load  (w_load),
    .i_data  (i_crc_in),
    .i_shift (w_shift),
    .o_head  (w_head),
    .o_last  (w_last)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= IDLE;
      r_zero_len <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == IDLE) && i_tx_start && !i_tx_abort)
        r_zero_len <= i_zero_len;
    end
  end

  // An abort overrides the state decode so clear_crc never overlaps enable/flag
  always_comb begin
    w_next          = r_state;
    o_clear_crc     = 1'b0;
    o_crc_enable    = 1'b0;
    o_crc_flag      = 1'b0;
    o_crc_bit_out   = 1'b0;
    o_crc_bit_valid = 1'b0;
    o_crc_busy      = (r_state != IDLE);
    o_crc_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_tx_start && !i_tx_abort)
          w_next = CLEAR;
      end
      CLEAR: begin
        o_clear_crc = 1'b1;
        w_next      = r_zero_len ? INVERT : DATA;
      end
      DATA: begin
        o_crc_enable = 1'b1;
        if (i_bit_strobe && i_payload_last)
          w_next = INVERT;
      end
      INVERT: begin
        o_crc_flag = 1'b1;
        w_next     = LATCH;
      end
      LATCH: begin
        w_next = SHIFT;
      end
      SHIFT: begin
        o_crc_bit_valid = 1'b1;
        o_crc_bit_out   = w_head;
        if (i_bit_strobe && w_last)
          w_next = DONE;
      end
      DONE: begin
        o_crc_done = 1'b1;
        w_next     = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
    if (w_abort) begin
      w_next          = IDLE;
      o_clear_crc     = 1'b1;
      o_crc_enable    = 1'b0;
      o_crc_flag      = 1'b0;
      o_crc_bit_out   = 1'b0;
      o_crc_bit_valid = 1'b0;
      o_crc_done      = 1'b0;
    end
  end

endmodule

// File: tb/tb_usb_tx_crc_sequencer.sv
// Self-checking bench: per-cycle vector records, built either by hand or from
// a packet timeline model, applied to an MSB-first and an LSB-first instance.
module tb_usb_tx_crc_sequencer;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        txStart = 1'b0;
  logic        zeroLen = 1'b0;
  logic        bitStrobe = 1'b0;
  logic        payloadLast = 1'b0;
  logic        txAbort = 1'b0;
  logic [15:0] crcIn = 16'h0;

  logic clrM, enM, flagM, bitM, vldM, busyM, doneM;
  logic clrL, enL, flagL, bitL, vldL, busyL, doneL;

  int vecCount = 0;
  int missCount = 0;

  typedef struct {
    logic        start;
    logic        zeroLen;
    logic        strobe;
    logic        last;
    logic        abort;
    logic        rstLow;
    logic [15:0] crcIn;
    logic [6:0]  expMsb;
    logic [6:0]  expLsb;
  } vec_t;

  vec_t vecQ[$];

  always #5 clk = ~clk;

  usb_tx_crc_sequencer #(.MSB_FIRST(1'b1)) dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .i_tx_start      (txStart),
    .i_zero_len      (zeroLen),
    .i_bit_strobe    (bitStrobe),
    .i_payload_last  (payloadLast),
    .i_tx_abort      (txAbort),
    .i_crc_in        (crcIn),
    .o_clear_crc     (clrM),
    .o_crc_enable    (enM),
    .o_crc_flag      (flagM),
    .o_crc_bit_out   (bitM),
    .o_crc_bit_valid (vldM),
    .o_crc_busy      (busyM),
    .o_crc_done      (doneM)
  );

  usb_tx_crc_sequencer #(.MSB_FIRST(1'b0)) dutLsb (
    .clk             (clk),
    .n_rst           (n_rst),
    .i_tx_start      (txStart),
    .i_zero_len      (zeroLen),
    .i_bit_strobe    (bitStrobe),
    .i_payload_last  (payloadLast),
    .i_tx_abort      (txAbort),
    .i_crc_in        (crcIn),
    .o_clear_crc     (clrL),
    .o_crc_enable    (enL),
    .o_crc_flag      (flagL),
    .o_crc_bit_out   (bitL),
    .o_crc_bit_valid (vldL),
    .o_crc_busy      (busyL),
    .o_crc_done      (doneL)
  );

  // Output vector order: {clear, enable, flag, valid, bit, busy, done}
  function automatic logic [6:0] packOut(input logic c, input logic e, input logic f,
                                         input logic v, input logic b, input logic bz,
                                         input logic d);
    return {c, e, f, v, b, bz, d};
  endfunction

  function automatic vec_t mkVec(input logic st, input logic zl, input logic sb,
                                 input logic ls, input logic ab, input logic rl,
                                 input logic [6:0] ex);
    vec_t r;
    r.start   = st;
    r.zeroLen = zl;
    r.strobe  = sb;
    r.last    = ls;
    r.abort   = ab;
    r.rstLow  = rl;
    r.crcIn   = 16'h0;
    r.expMsb  = ex;
    r.expLsb  = ex;
    return r;
  endfunction

  // Timeline model of one packet: relative cycle 0 carries tx_start; every
  // expected output follows from the strobe schedule with plain arithmetic.
  task automatic buildPacket(input bit zl, input int nPay, input logic [15:0] crc,
                             input int cutAt, input bit cutIsReset, input bit noise);
    int   payS[$];
    int   crcS[$];
    int   s, f, c, d, endIdx, k, lastPay;
    bit   inPay, inCrc, cut, busy, valid;
    vec_t r;
    if (!zl) begin
      s = 2 + $urandom_range(0, 3);
      for (int i = 0; i < nPay; i++) begin
        payS.push_back(s);
        s += 4 + $urandom_range(0, 3);
      end
      lastPay = payS[payS.size()-1];
      f = lastPay + 1;
      c = f + 3 + $urandom_range(0, 2);
    end else begin
      lastPay = -1;
      f = 2;
      c = f + 2 + $urandom_range(0, 2);
    end
    for (int i = 0; i < 16; i++) begin
      crcS.push_back(c);
      c += 4 + $urandom_range(0, 2);
    end
    d = crcS[15] + 1;
    endIdx = d + 2;
    if (cutAt >= 0 && cutAt + 2 < endIdx)
      endIdx = cutAt + 2;
    for (int x = 0; x < endIdx; x++) begin
      inPay = 1'b0;
      inCrc = 1'b0;
      k = 0;
      foreach (payS[i]) if (payS[i] == x) inPay = 1'b1;
      foreach (crcS[i]) begin
        if (crcS[i] == x) inCrc = 1'b1;
        if (crcS[i] < x) k++;
      end
      cut = (cutAt >= 0) && (x > cutAt);
      r.start   = (x == 0);
      r.zeroLen = (x == 0) ? zl : 1'($urandom);
      r.strobe  = inPay || inCrc;
      r.last    = (x == lastPay);
      if (noise) begin
        if (x >= 1 && x <= d && $urandom_range(0, 7) == 0) r.start = 1'b1;
        if (!r.strobe && $urandom_range(0, 3) == 0) r.last = 1'b1;
        if (inCrc) r.last = 1'($urandom);
        if (x == f || x == f + 1) begin
          r.strobe = 1'b1;
          r.last   = 1'($urandom);
        end
      end
      r.abort  = (x == cutAt) && !cutIsReset;
      r.rstLow = (x == cutAt) && cutIsReset;
      r.crcIn  = (x == f + 1) ? crc : 16'($urandom);
      if (cut) begin
        r.start  = 1'b0;
        r.strobe = 1'b0;
        r.last   = 1'b0;
      end
      busy  = (x >= 1) && (x <= d);
      valid = (x >= f + 2) && (x <= crcS[15]);
      if (cut || r.rstLow) begin
        r.expMsb = 7'b0;
        r.expLsb = 7'b0;
      end else if (r.abort && busy) begin
        r.expMsb = packOut(1, 0, 0, 0, 0, 1, 0);
        r.expLsb = r.expMsb;
      end else begin
        r.expMsb = packOut(x == 1, !zl && x >= 2 && x <= lastPay, x == f, valid,
                           valid ? crc[15-k] : 1'b0, busy, x == d);
        r.expLsb = packOut(x == 1, !zl && x >= 2 && x <= lastPay, x == f, valid,
                           valid ? crc[k] : 1'b0, busy, x == d);
      end
      vecQ.push_back(r);
    end
  endtask

  task automatic checkOutput(input string tag, input int idx, input vec_t r);
    logic [6:0] actM, actL;
    actM = packOut(clrM, enM, flagM, vldM, bitM, busyM, doneM);
    actL = packOut(clrL, enL, flagL, vldL, bitL, busyL, doneL);
    vecCount++;
    if (actM !== r.expMsb || actL !== r.expLsb) begin
      missCount++;
      $display("[TB] FAIL %s[%0d] {clr,en,flag,vld,bit,busy,done}: msb got %b want %b, lsb got %b want %b",
               tag, idx, actM, r.expMsb, actL, r.expLsb);
    end
  endtask

  // Inputs change 1ns after the edge; outputs are sampled on the falling edge
  task automatic applyStimulus(input string tag);
    foreach (vecQ[i]) begin
      @(posedge clk);
      #1;
      txStart     = vecQ[i].start;
      zeroLen     = vecQ[i].zeroLen;
      bitStrobe   = vecQ[i].strobe;
      payloadLast = vecQ[i].last;
      txAbort     = vecQ[i].abort;
      crcIn       = vecQ[i].crcIn;
      n_rst       = !vecQ[i].rstLow;
      @(negedge clk);
      checkOutput(tag, i, vecQ[i]);
    end
    vecQ.delete();
  endtask

  initial begin
    vec_t idleTab[8];
    bit   zl;
    int   cutAt;

    idleTab[0] = mkVec(0, 0, 0, 0, 0, 1, packOut(0, 0, 0, 0, 0, 0, 0));
    idleTab[1] = mkVec(0, 0, 0, 0, 1, 0, packOut(0, 0, 0, 0, 0, 0, 0));
    idleTab[2] = mkVec(1, 0, 0, 0, 1, 0, packOut(0, 0, 0, 0, 0, 0, 0));
    idleTab[3] = mkVec(0, 0, 0, 0, 0, 0, packOut(0, 0, 0, 0, 0, 0, 0));
    idleTab[4] = mkVec(1, 0, 0, 0, 0, 0, packOut(0, 0, 0, 0, 0, 0, 0));
    idleTab[5] = mkVec(0, 0, 0, 0, 0, 0, packOut(1, 0, 0, 0, 0, 1, 0));
    idleTab[6] = mkVec(0, 0, 1, 0, 1, 0, packOut(1, 0, 0, 0, 0, 1, 0));
    idleTab[7] = mkVec(0, 0, 0, 0, 0, 0, packOut(0, 0, 0, 0, 0, 0, 0));
    foreach (idleTab[i]) vecQ.push_back(idleTab[i]);
    applyStimulus("idleTable");

    buildPacket(0, 8, 16'hA5C3, -1, 0, 0);
    applyStimulus("normal");
    buildPacket(1, 0, 16'hA5C3, -1, 0, 0);
    applyStimulus("zeroLen");
    buildPacket(0, 8, 16'($urandom), 5, 0, 0);
    applyStimulus("abortData");
    buildPacket(0, 8, 16'hA5C3, -1, 0, 0);
    applyStimulus("afterAbortData");
    buildPacket(0, 2, 16'($urandom), 40, 0, 0);
    applyStimulus("abortShift");
    buildPacket(0, 3, 16'h1234, -1, 0, 0);
    applyStimulus("afterAbortShift");
    buildPacket(0, 2, 16'($urandom), 40, 1, 0);
    applyStimulus("resetShift");
    buildPacket(0, 4, 16'hBEEF, -1, 0, 0);
    applyStimulus("afterReset");
    buildPacket(0, 8, 16'hA5C3, -1, 0, 1);
    applyStimulus("startInShift");

    for (int p = 0; p < 24; p++) begin
      zl    = ($urandom_range(0, 3) == 0);
      cutAt = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 100)) : -1;
      buildPacket(zl, int'($urandom_range(1, 12)), 16'($urandom), cutAt,
                  1'($urandom), 1'($urandom));
      applyStimulus("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
